regfile_wb_queue: RTL and testbench

- Write-back side of the register file. Accepts register results from execution units over a valid/ready handshake and buffers them in a small in-order FIFO.
- Drains one entry per cycle into the register file write port (rd/d/we) whenever the write port is granted.
- Forwards pending (not yet written) values onto the register-file read data, so readers never see stale registers.

---
 rtl/regfile_pkg.sv | 21 ++
 rtl/wb_fwd_mux.sv | 40 ++++
 rtl/regfile_wb_queue.sv | 106 ++++++++++
 tb/tb_regfile_wb_queue.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-back path.
//   addr_width()  register address width for a given register count
//   REG_ZERO      hard-wired zero register; never written, never forwarded
//   wb_entry_t    one pending write {rd, data} at the default configuration
package regfile_pkg;

    function automatic int addr_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int RF_DATA_W   = 32;
    localparam int RF_NUM_REGS = 32;
    localparam int RF_AW       = addr_width(RF_NUM_REGS);
    localparam int REG_ZERO    = 0;

    typedef struct packed {
        logic [RF_AW-1:0]     rd;
        logic [RF_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fwd_mux.sv
// Forwarding mux for one register-file read port.
// Scans the pending entries from oldest (rd_ptr) to youngest; the last match
// wins, so the youngest pending value for ra replaces the register-file data.
//   ent_rd/ent_data  entry array (slot-indexed)
//   rd_ptr, count    head slot and number of valid entries
//   ra, rf_q         read address and raw register-file read data
//   q                forwarded read data
module wb_fwd_mux
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int AW         = 5,
    parameter int DEPTH      = 4,
    localparam int PW        = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][AW-1:0]         ent_rd,
    input  logic [DEPTH-1:0][DATA_WIDTH-1:0] ent_data,
    input  logic [PW-1:0]                    rd_ptr,
    input  logic [PW:0]                      count,
    input  logic [AW-1:0]                    ra,
    input  logic [DATA_WIDTH-1:0]            rf_q,
    output logic [DATA_WIDTH-1:0]            q
);

    logic [PW-1:0] slot;

    always_comb begin
        q    = rf_q;
        slot = rd_ptr;
        if (ra != AW'(REG_ZERO)) begin
            for (int k = 0; k < DEPTH; k++) begin
                // age k from the head; pointer arithmetic wraps modulo DEPTH
                slot = rd_ptr + PW'(k);
                if (((PW+1)'(k) < count) && (ent_rd[slot] == ra))
                    q = ent_data[slot];
            end
        end
    end

endmodule

// File: rtl/regfile_wb_queue.sv
// Write-back queue in front of the register-file write port.
// Buffers execution results in an in-order FIFO, retires one per granted
// cycle, and forwards pending values onto both register-file read ports.
//   clk, rst                  clock, async active-high reset
//   in_valid/in_ready/in_rd/in_data   result handshake from execution units
//   drain_en                  write port granted this cycle
//   rf_we/rf_rd/rf_d          register-file write port
//   fwd_ra/fwd_rb, rf_qa/rf_qb, qa/qb   read addresses, raw and forwarded data
//   empty                     no pending entries
module regfile_wb_queue
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int DEPTH      = 4,
    localparam int AW        = addr_width(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [AW-1:0]         in_rd,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  drain_en,
    output logic                  rf_we,
    output logic [AW-1:0]         rf_rd,
    output logic [DATA_WIDTH-1:0] rf_d,
    input  logic [AW-1:0]         fwd_ra,
    input  logic [AW-1:0]         fwd_rb,
    input  logic [DATA_WIDTH-1:0] rf_qa,
    input  logic [DATA_WIDTH-1:0] rf_qb,
    output logic [DATA_WIDTH-1:0] qa,
    output logic [DATA_WIDTH-1:0] qb,
    output logic                  empty
);

    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0][AW-1:0]         ent_rd;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] ent_data;
    logic [PW-1:0]                    wr_ptr, rd_ptr;
    logic [PW:0]                      count;
    logic                             push, pop;

    assign in_ready = (count != (PW+1)'(DEPTH));
    assign empty    = (count == '0);
    // writes to the zero register complete the handshake but are dropped
    assign push     = in_valid && in_ready && (in_rd != AW'(REG_ZERO));
    assign pop      = drain_en && !empty;
    assign rf_we    = pop;
    // zero when empty so uninitialised slots never leak X into the RF
    assign rf_rd    = empty ? '0 : ent_rd[rd_ptr];
    assign rf_d     = empty ? '0 : ent_data[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // entry contents carry no reset; validity is tracked by count
    always_ff @(posedge clk) begin
        if (push) begin
            ent_rd[wr_ptr]   <= in_rd;
            ent_data[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && !pop && count == (PW+1)'(DEPTH)));
            assert (!(pop && !push && count == '0));
        end
    end

    wb_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .AW(AW), .DEPTH(DEPTH)) u_fwd_a (
        .ent_rd   (ent_rd),
        .ent_data (ent_data),
        .rd_ptr   (rd_ptr),
        .count    (count),
        .ra       (fwd_ra),
        .rf_q     (rf_qa),
        .q        (qa)
    );

    wb_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .AW(AW), .DEPTH(DEPTH)) u_fwd_b (
        .ent_rd   (ent_rd),
        .ent_data (ent_data),
        .rd_ptr   (rd_ptr),
        .count    (count),
        .ra       (fwd_rb),
        .rf_q     (rf_qb),
        .q        (qb)
    );

endmodule

// File: tb/tb_regfile_wb_queue.sv
module tb_regfile_wb_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [4:0]  in_rd;
    logic [31:0] in_data;
    logic        drain_en, rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_d;
    logic [4:0]  fwd_ra, fwd_rb;
    logic [31:0] rf_qa, rf_qb, qa, qb;
    logic        empty;

    int checks = 0;
    int errors = 0;

    regfile_wb_queue #(.DATA_WIDTH(32), .NUM_REGS(32), .DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_rd    (in_rd),
        .in_data  (in_data),
        .drain_en (drain_en),
        .rf_we    (rf_we),
        .rf_rd    (rf_rd),
        .rf_d     (rf_d),
        .fwd_ra   (fwd_ra),
        .fwd_rb   (fwd_rb),
        .rf_qa    (rf_qa),
        .rf_qb    (rf_qb),
        .qa       (qa),
        .qb       (qb),
        .empty    (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // advance one edge; inputs change 1 time unit after it
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] d);
        in_valid = 1'b1; in_rd = rd; in_data = d;
        cyc();
        in_valid = 1'b0;
    endtask

    // stream-test bookkeeping
    logic [4:0] exp_q[$];
    int         accepted, writes;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_data = '0; drain_en = 1'b1;
        fwd_ra = 5'd0; fwd_rb = 5'd0; rf_qa = 32'h1111_0000; rf_qb = 32'h2222_0000;
        cyc(); cyc();
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_rf_we",    rf_we,    0);
        chk("rst_empty",    empty,    1);
        chk("rst_qa",       qa,       32'h1111_0000);
        rst = 1'b0; drain_en = 1'b0;
        cyc();

        // single push, forward, then drain
        push(5'd5, 32'hAAAA_0001);
        fwd_ra = 5'd5; rf_qa = 32'h0; #1;
        chk("t1_empty", empty, 0);
        chk("t1_qa",    qa,    32'hAAAA_0001);
        chk("t1_no_we", rf_we, 0);
        drain_en = 1'b1; #1;
        chk("t1_we", rf_we, 1);
        chk("t1_rd", rf_rd, 5);
        chk("t1_d",  rf_d,  32'hAAAA_0001);
        cyc();
        chk("t1_empty_after", empty, 1);
        chk("t1_we_after",    rf_we, 0);
        drain_en = 1'b0;

        // fill to full, refuse a 5th, drain in order
        for (int i = 0; i < 4; i++) push(5'(i + 1), 32'h10 + 32'(i));
        chk("t2_full_ready", in_ready, 0);
        fwd_ra = 5'd3; #1;
        chk("t2_fwd_full", qa, 32'h12);
        in_valid = 1'b1; in_rd = 5'd9; in_data = 32'h99;
        cyc();
        in_valid = 1'b0;
        chk("t2_still_full", in_ready, 0);
        drain_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_we", rf_we, 1);
            chk("t2_rd", rf_rd, 32'(i + 1));
            chk("t2_d",  rf_d,  32'h10 + 32'(i));
            cyc();
            if (i == 0) chk("t2_ready_after_pop", in_ready, 1);
        end
        chk("t2_empty", empty, 1);
        drain_en = 1'b0;

        // same-rd pending twice: youngest forwarded
        push(5'd7, 32'h1);
        push(5'd7, 32'h2);
        fwd_rb = 5'd7; rf_qb = 32'h55; #1;
        chk("t3_qb_two", qb, 32'h2);
        chk("t3_head", rf_d, 32'h1);
        drain_en = 1'b1; cyc(); drain_en = 1'b0; #1;
        chk("t3_qb_one", qb, 32'h2);
        chk("t3_head2", rf_d, 32'h2);
        drain_en = 1'b1; cyc(); drain_en = 1'b0; #1;
        chk("t3_qb_none", qb, 32'h55);

        // writes to r0 are dropped
        in_valid = 1'b1; in_rd = 5'd0; in_data = 32'hDEAD; #1;
        chk("t4_ready", in_ready, 1);
        cyc();
        in_valid = 1'b0; drain_en = 1'b1; fwd_ra = 5'd0; rf_qa = 32'h1234; #1;
        chk("t4_empty", empty, 1);
        chk("t4_no_we", rf_we, 0);
        chk("t4_qa",    qa,    32'h1234);
        drain_en = 1'b0;

        // full queue under continuous push + drain
        exp_q.delete(); accepted = 0; writes = 0;
        for (int i = 0; i < 4; i++) begin
            push(5'(i + 1), 32'h20 + 32'(i));
            exp_q.push_back(5'(i + 1));
            accepted++;
        end
        drain_en = 1'b1;
        for (int n = 0; n < 20; n++) begin
            in_valid = (n < 12);
            in_rd    = (n % 5 == 2) ? 5'd0 : 5'(10 + n);
            in_data  = 32'h100 + 32'(n);
            #1;
            if (rf_we) begin
                writes++;
                if (exp_q.size() == 0) chk("t5_spurious_we", rf_we, 0);
                else chk("t5_order", rf_rd, exp_q.pop_front());
            end
            if (in_valid && in_ready && in_rd != 5'd0) begin
                exp_q.push_back(in_rd);
                accepted++;
            end
            if (n == 0) chk("t5_full_no_accept", in_ready, 0);
            cyc();
        end
        in_valid = 1'b0;
        chk("t5_count", writes, accepted);
        chk("t5_empty", empty, 1);
        drain_en = 1'b0;

        // reset mid-drain discards pending entries
        for (int i = 0; i < 4; i++) push(5'(i + 1), 32'h30 + 32'(i));
        drain_en = 1'b1; cyc();
        rst = 1'b1; #1;
        chk("t6_we",    rf_we,    0);
        chk("t6_empty", empty,    1);
        chk("t6_ready", in_ready, 1);
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t6_no_write", rf_we, 0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
